hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller that drives the enable, bubble and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It reads the decoded source fields of the instruction in ID and the destination and control bits already latched in ID/EX and EX/MEM. From these it produces operand-forwarding selects, load-use bubbles, branch flushes and memory-wait freezes. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects, load-use bubbles,
// branch flushes, memory-wait freezes, stall counter and sticky timeout.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;

    // EX result wins over MEM result; a load in EX has no result yet.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (ex_reg_write && !ex_mem_read && ex_rd != '0 && ex_rd == src)
            return 2'b01;
        else if (mem_reg_write && mem_rd != '0 && mem_rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // decision tree leaves it unassigned, which would infer a latch.
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_bubble = 1'b0;
        exmem_write = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (state != ERROR) begin
            fwd_a = fwd_sel(id_rs);
            fwd_b = fwd_sel(id_rt);
            if (!mem_busy) begin
                exmem_write = 1'b1;
                idex_write  = 1'b1;
                if (ex_branch_taken) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    idex_bubble = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            if (!pc_write && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state       <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int MT    = 4;

    logic             clock;
    logic             resetn;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic             id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write;
    logic             ex_branch_taken, mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
        .clock(clock), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int rs, rt, ex_rd, mem_rd;
        bit uses_rt, ex_rw, ex_mr, mem_rw, br, busy;
    } stim_t;

    typedef struct {
        bit pc, ifid, flush, idex, bubble, exmem;
        int fa, fb;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: sticky error flag, length of the current busy run,
    // and the number of stall cycles seen since reset.
    bit m_error   = 0;
    int busy_run  = 0;
    int m_stall   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rs = 0; s.rt = 0; s.ex_rd = 0; s.mem_rd = 0;
        s.uses_rt = 0; s.ex_rw = 0; s.ex_mr = 0; s.mem_rw = 0; s.br = 0; s.busy = 0;
        return s;
    endfunction

    function automatic int src_of(stim_t s, int r);
        if (s.ex_rw && !s.ex_mr && s.ex_rd != 0 && s.ex_rd == r) return 1;
        if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == r) return 2;
        return 0;
    endfunction

    function automatic exp_t model_out(stim_t s);
        exp_t e;
        bit   hazard;
        e = '{default: 0};
        if (m_error) return e;
        hazard = s.ex_mr && s.ex_rd != 0 &&
                 (s.ex_rd == s.rs || (s.uses_rt && s.ex_rd == s.rt));
        e.fa = src_of(s, s.rs);
        e.fb = src_of(s, s.rt);
        if (s.busy) return e;
        e.idex = 1; e.exmem = 1;
        if (s.br) begin
            e.pc = 1; e.ifid = 1; e.flush = 1; e.bubble = 1;
        end else if (hazard) begin
            e.bubble = 1;
        end else begin
            e.pc = 1; e.ifid = 1;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_error = 0; busy_run = 0; m_stall = 0;
    endtask

    task automatic drive(stim_t s);
        id_rs = REG_W'(s.rs); id_rt = REG_W'(s.rt); id_uses_rt = s.uses_rt;
        ex_rd = REG_W'(s.ex_rd); ex_reg_write = s.ex_rw; ex_mem_read = s.ex_mr;
        mem_rd = REG_W'(s.mem_rd); mem_reg_write = s.mem_rw;
        ex_branch_taken = s.br; mem_busy = s.busy;
    endtask

    // One cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic apply(stim_t s);
        exp_t e;
        drive(s);
        e = model_out(s);
        @(negedge clock);
        check("pc_write",    pc_write,    e.pc);
        check("ifid_write",  ifid_write,  e.ifid);
        check("ifid_flush",  ifid_flush,  e.flush);
        check("idex_write",  idex_write,  e.idex);
        check("idex_bubble", idex_bubble, e.bubble);
        check("exmem_write", exmem_write, e.exmem);
        check("fwd_a",       fwd_a,       e.fa);
        check("fwd_b",       fwd_b,       e.fb);
        check("stall_count", stall_count, m_stall);
        check("mem_timeout", mem_timeout, m_error);
        @(posedge clock);
        if (!resetn) begin
            model_reset();
        end else begin
            if (!e.pc && m_stall < 15) m_stall++;
            if (!m_error) begin
                if (s.busy) begin
                    busy_run++;
                    if (busy_run > MT) m_error = 1;
                end else begin
                    busy_run = 0;
                end
            end
        end
        #1;
    endtask

    task automatic async_reset_pulse();
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check("rst_stall_count", stall_count, 0);
        check("rst_mem_timeout", mem_timeout, 0);
        apply(idle());
        resetn = 1'b1;
    endtask

    initial begin
        stim_t s;
        drive(idle());
        resetn = 1'b0;
        #1;
        // Reset: RUN decisions while held in reset
        apply(idle());
        s = idle(); s.ex_mr = 1; s.ex_rd = 3; s.rs = 3;
        apply(s);
        resetn = 1'b1;

        // Load-use stall then forward from MEM
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.rs = 5;
        apply(s);
        check("lu_stall_count", stall_count, 1);
        s = idle(); s.mem_rd = 5; s.mem_rw = 1; s.rs = 5;
        apply(s);
        check("lu_fwd_a_after", fwd_a, 2'b10);

        // Forward priority and register-0 suppression
        s = idle(); s.ex_rd = 7; s.mem_rd = 7; s.ex_rw = 1; s.mem_rw = 1; s.rt = 7;
        apply(s);
        s.ex_rd = 0; s.rs = 0; s.mem_rd = 0;
        apply(s);
        s = idle(); s.ex_rd = 9; s.mem_rd = 9; s.ex_rw = 1; s.ex_mr = 1; s.mem_rw = 1;
        s.rs = 9; s.rt = 9; s.uses_rt = 0;
        apply(s);

        // Branch beats load-use; load-use via rt only when rt is used
        s = idle(); s.ex_mr = 1; s.ex_rd = 4; s.rs = 4; s.br = 1;
        apply(s);
        s = idle(); s.ex_mr = 1; s.ex_rd = 6; s.rt = 6; s.uses_rt = 0;
        apply(s);
        s.uses_rt = 1;
        apply(s);

        // Memory wait of three cycles, with a branch pending under the freeze
        async_reset_pulse();
        s = idle(); s.busy = 1; s.br = 1;
        repeat (3) apply(s);
        s.busy = 0;
        apply(s);
        check("mw_stall_count", stall_count, 3);
        check("mw_mem_timeout", mem_timeout, 0);

        // Timeout: error becomes sticky, then async reset clears it
        s = idle(); s.busy = 1;
        repeat (MT + 2) apply(s);
        s.busy = 0; s.ex_rw = 1; s.ex_rd = 2; s.rs = 2;
        repeat (2) apply(s);
        check("to_sticky", mem_timeout, 1);
        async_reset_pulse();
        apply(s);

        // Saturation of the stall counter
        s = idle(); s.ex_mr = 1; s.ex_rd = 8; s.rs = 8;
        repeat (20) apply(s);
        check("sat_stall_count", stall_count, 15);

        // Random traffic against the model
        async_reset_pulse();
        for (int i = 0; i < 300; i++) begin
            s.rs = $urandom_range(0, 3);  s.rt = $urandom_range(0, 3);
            s.ex_rd = $urandom_range(0, 3); s.mem_rd = $urandom_range(0, 3);
            s.uses_rt = $urandom_range(0, 1); s.ex_rw = $urandom_range(0, 1);
            s.ex_mr = $urandom_range(0, 1); s.mem_rw = $urandom_range(0, 1);
            s.br = ($urandom_range(0, 3) == 0);
            s.busy = ($urandom_range(0, 4) == 0);
            apply(s);
            if (i % 60 == 59) async_reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
